// File: rtl/pool_stream_buffer.sv
// rtl/pool_stream_buffer.sv - per-channel KxK max/avg pooling into a DEPTH-entry frame buffer
module pool_stream_buffer #(
   parameter int NUM_CHANNELS = 6,
   parameter int DATA_WIDTH   = 5,
   parameter int WIN_DIM      = 3,
   parameter int DEPTH        = 16
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  mode,
   input  logic                                                  in_valid,
   output logic                                                  in_ready,
   input  logic [NUM_CHANNELS*WIN_DIM*WIN_DIM*DATA_WIDTH-1:0]    data_in,
   input  logic                                                  clear,
   input  logic                                                  rd_en,
   input  logic [$clog2(DEPTH)-1:0]                              rd_addr,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0]                    rd_data,
   output logic                                                  rd_valid,
   output logic [$clog2(DEPTH+1)-1:0]                            count,
   output logic                                                  full,
   output logic                                                  frame_done
);

   localparam int KK    = WIN_DIM * WIN_DIM;
   localparam int SUM_W = DATA_WIDTH + $clog2(KK);
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int RW    = NUM_CHANNELS * DATA_WIDTH;

   logic [RW-1:0] mem [DEPTH];
   logic [RW-1:0] red_data;
   logic [RW-1:0] s1_data;
   logic          s1_valid;
   logic [AW-1:0] wr_ptr;
   logic          out_of_reset;
   logic [CW:0]   occupancy;
   logic          accept;
   logic          wr_fire;

   // A slot is reserved as soon as a beat is accepted, so the in-flight
   // stage-1 result counts against capacity and the buffer never overflows.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, s1_valid};
   assign in_ready  = out_of_reset && (occupancy < (CW+1)'(DEPTH)) && !clear;
   assign accept    = in_valid && in_ready;
   assign wr_fire   = s1_valid && !clear;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [DATA_WIDTH-1:0] mx;
      logic [DATA_WIDTH-1:0] av;
      logic [SUM_W-1:0]      sm;

      // Reduce one channel's window to its maximum and its floored mean.
      always_comb begin
         mx = '0;
         sm = '0;
         for (int e = 0; e < KK; e++) begin
            if (data_in[(c*KK+e)*DATA_WIDTH +: DATA_WIDTH] > mx)
               mx = data_in[(c*KK+e)*DATA_WIDTH +: DATA_WIDTH];
            sm = sm + SUM_W'(data_in[(c*KK+e)*DATA_WIDTH +: DATA_WIDTH]);
         end
         av = DATA_WIDTH'(sm / SUM_W'(KK));
      end

      assign red_data[c*DATA_WIDTH +: DATA_WIDTH] = mode ? av : mx;
   end

   // in_ready stays low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) out_of_reset <= 1'b0;
      else      out_of_reset <= 1'b1;
   end

   // Stage 1: capture the reduced beat; clear drops anything in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else if (clear) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) s1_data <= red_data;
      end
   end

   // Write-side bookkeeping: pointer, count, full flag and done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         count      <= '0;
         full       <= 1'b0;
         frame_done <= 1'b0;
      end else if (clear) begin
         wr_ptr     <= '0;
         count      <= '0;
         full       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
            if (count == CW'(DEPTH - 1)) begin
               full       <= 1'b1;
               frame_done <= 1'b1;
            end
         end
      end
   end

   // Buffer storage; contents survive reset and clear.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr] <= s1_data;
   end

   // Registered read port; entries not yet counted read back as zero,
   // which also covers a read racing the write of the same entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if (rd_en) begin
         rd_valid <= 1'b1;
         rd_data  <= (CW'(rd_addr) < count) ? mem[rd_addr] : '0;
      end else begin
         rd_valid <= 1'b0;
      end
   end

endmodule
